// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: ALU opcodes, datapath widths and
// the packed control bundle carried from Decode into Execute.
package mips_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic       valid;
      logic [2:0] alu_control;
      logic       alu_src;
      logic       reg_dst;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
   } ex_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load sitting in Execute and the
// instruction waiting in Decode. Loads always write rt, so only rt is checked.
module hazard_detect
   import mips_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
   input  logic                  ex_valid_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rt_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   output logic                  hazard_o
);

   // $zero never carries a dependency; an empty decode slot never stalls.
   always_comb begin
      hazard_o = ex_valid_i & ex_mem_read_i & id_valid_i & (ex_rt_i != '0) &
                 ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
   end

endmodule

// File: rtl/id_ex_reg.sv
// Decode/Execute pipeline register with load-use bubble insertion, flush,
// stall hold and a saturating bubble counter.
module id_ex_reg
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W     = mips_pkg::DATA_W,
   parameter int unsigned REG_ADDR_W = mips_pkg::REG_ADDR_W,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  id_valid_i,
   input  logic [2:0]            id_alu_control_i,
   input  logic                  id_alu_src_i,
   input  logic                  id_reg_dst_i,
   input  logic                  id_reg_write_i,
   input  logic                  id_mem_read_i,
   input  logic                  id_mem_write_i,
   input  logic                  id_mem_to_reg_i,
   input  logic                  id_branch_i,
   input  logic [DATA_W-1:0]     id_rd1_i,
   input  logic [DATA_W-1:0]     id_rd2_i,
   input  logic [DATA_W-1:0]     id_imm_i,
   input  logic [DATA_W-1:0]     id_pc4_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   output logic                  ex_valid_o,
   output logic [2:0]            ex_alu_control_o,
   output logic                  ex_alu_src_o,
   output logic                  ex_reg_dst_o,
   output logic                  ex_reg_write_o,
   output logic                  ex_mem_read_o,
   output logic                  ex_mem_write_o,
   output logic                  ex_mem_to_reg_o,
   output logic                  ex_branch_o,
   output logic [DATA_W-1:0]     ex_rd1_o,
   output logic [DATA_W-1:0]     ex_rd2_o,
   output logic [DATA_W-1:0]     ex_imm_o,
   output logic [DATA_W-1:0]     ex_pc4_o,
   output logic [REG_ADDR_W-1:0] ex_rs_o,
   output logic [REG_ADDR_W-1:0] ex_rt_o,
   output logic [REG_ADDR_W-1:0] ex_rd_o,
   output logic                  hazard_o,
   output logic [CNT_W-1:0]      bubble_count_o
);

   ex_ctrl_t              ctrl_q;
   ex_ctrl_t              id_ctrl;
   logic [DATA_W-1:0]     rd1_q, rd2_q, imm_q, pc4_q;
   logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  hazard;
   logic                  load_bubble;
   logic                  load_id;

   hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard_detect (
      .ex_valid_i    (ctrl_q.valid),
      .ex_mem_read_i (ctrl_q.mem_read),
      .ex_rt_i       (rt_q),
      .id_valid_i    (id_valid_i),
      .id_rs_i       (id_rs_i),
      .id_rt_i       (id_rt_i),
      .hazard_o      (hazard)
   );

   // Gather decode control into one bundle; pick bubble/hold/load by priority.
   // Flush beats stall; stall beats hazard so a stalled hazard simply holds.
   always_comb begin
      id_ctrl             = '0;
      id_ctrl.valid       = id_valid_i;
      id_ctrl.alu_control = id_alu_control_i;
      id_ctrl.alu_src     = id_alu_src_i;
      id_ctrl.reg_dst     = id_reg_dst_i;
      id_ctrl.reg_write   = id_reg_write_i;
      id_ctrl.mem_read    = id_mem_read_i;
      id_ctrl.mem_write   = id_mem_write_i;
      id_ctrl.mem_to_reg  = id_mem_to_reg_i;
      id_ctrl.branch      = id_branch_i;
      load_bubble         = flush_i | (~stall_i & hazard);
      load_id             = ~flush_i & ~stall_i & ~hazard;
   end

   // Pipeline register: a bubble zeroes every field including data.
   always_ff @(posedge clk) begin
      if (reset || load_bubble) begin
         ctrl_q <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
         imm_q  <= '0;
         pc4_q  <= '0;
         rs_q   <= '0;
         rt_q   <= '0;
         rd_q   <= '0;
      end else if (load_id) begin
         ctrl_q <= id_ctrl;
         rd1_q  <= id_rd1_i;
         rd2_q  <= id_rd2_i;
         imm_q  <= id_imm_i;
         pc4_q  <= id_pc4_i;
         rs_q   <= id_rs_i;
         rt_q   <= id_rt_i;
         rd_q   <= id_rd_i;
      end
   end

   // Saturating count of inserted bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load_bubble && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Drive outputs from the registered state.
   always_comb begin
      ex_valid_o       = ctrl_q.valid;
      ex_alu_control_o = ctrl_q.alu_control;
      ex_alu_src_o     = ctrl_q.alu_src;
      ex_reg_dst_o     = ctrl_q.reg_dst;
      ex_reg_write_o   = ctrl_q.reg_write;
      ex_mem_read_o    = ctrl_q.mem_read;
      ex_mem_write_o   = ctrl_q.mem_write;
      ex_mem_to_reg_o  = ctrl_q.mem_to_reg;
      ex_branch_o      = ctrl_q.branch;
      ex_rd1_o         = rd1_q;
      ex_rd2_o         = rd2_q;
      ex_imm_o         = imm_q;
      ex_pc4_o         = pc4_q;
      ex_rs_o          = rs_q;
      ex_rt_o          = rt_q;
      ex_rd_o          = rd_q;
      hazard_o         = hazard;
      bubble_count_o   = cnt_q;
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: a driver issues one decode slot per cycle
// and queues the reference model's expectation; a monitor checks hazard_o
// before the edge and the registered outputs after it.
module tb_id_ex_reg;
   import mips_pkg::*;

   typedef struct packed {
      logic        valid;
      logic [2:0]  alu_control;
      logic        alu_src;
      logic        reg_dst;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        branch;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } slot_t;

   typedef struct packed {
      logic        hazard;
      slot_t       ex;
      logic [15:0] cnt;
   } exp_t;

   localparam int CNT_MAX = 65535;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   slot_t       id;
   slot_t       act;
   logic        hazard;
   logic [15:0] count;

   logic        ex_valid, ex_alu_src, ex_reg_dst, ex_reg_write, ex_mem_read;
   logic        ex_mem_write, ex_mem_to_reg, ex_branch;
   logic [2:0]  ex_alu_control;
   logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
   logic [4:0]  ex_rs, ex_rt, ex_rd;

   int    n_checks = 0;
   int    n_fail   = 0;
   exp_t  q[$];
   slot_t m_ex;
   int    m_cnt;

   always #5 clk = ~clk;

   id_ex_reg dut (
      .clk              (clk),
      .reset            (reset),
      .stall_i          (stall),
      .flush_i          (flush),
      .id_valid_i       (id.valid),
      .id_alu_control_i (id.alu_control),
      .id_alu_src_i     (id.alu_src),
      .id_reg_dst_i     (id.reg_dst),
      .id_reg_write_i   (id.reg_write),
      .id_mem_read_i    (id.mem_read),
      .id_mem_write_i   (id.mem_write),
      .id_mem_to_reg_i  (id.mem_to_reg),
      .id_branch_i      (id.branch),
      .id_rd1_i         (id.rd1),
      .id_rd2_i         (id.rd2),
      .id_imm_i         (id.imm),
      .id_pc4_i         (id.pc4),
      .id_rs_i          (id.rs),
      .id_rt_i          (id.rt),
      .id_rd_i          (id.rd),
      .ex_valid_o       (ex_valid),
      .ex_alu_control_o (ex_alu_control),
      .ex_alu_src_o     (ex_alu_src),
      .ex_reg_dst_o     (ex_reg_dst),
      .ex_reg_write_o   (ex_reg_write),
      .ex_mem_read_o    (ex_mem_read),
      .ex_mem_write_o   (ex_mem_write),
      .ex_mem_to_reg_o  (ex_mem_to_reg),
      .ex_branch_o      (ex_branch),
      .ex_rd1_o         (ex_rd1),
      .ex_rd2_o         (ex_rd2),
      .ex_imm_o         (ex_imm),
      .ex_pc4_o         (ex_pc4),
      .ex_rs_o          (ex_rs),
      .ex_rt_o          (ex_rt),
      .ex_rd_o          (ex_rd),
      .hazard_o         (hazard),
      .bubble_count_o   (count)
   );

   assign act = {ex_valid, ex_alu_control, ex_alu_src, ex_reg_dst, ex_reg_write, ex_mem_read,
                 ex_mem_write, ex_mem_to_reg, ex_branch, ex_rd1, ex_rd2, ex_imm, ex_pc4,
                 ex_rs, ex_rt, ex_rd};

   // Apply one cycle of stimulus and queue what the model predicts for it.
   task automatic drive(input logic rst, input logic fl, input logic st, input slot_t in);
      exp_t e;
      bit   haz;
      @(negedge clk);
      reset = rst;
      flush = fl;
      stall = st;
      id    = in;
      haz = m_ex.valid && m_ex.mem_read && in.valid && (m_ex.rt != 0) &&
            ((m_ex.rt == in.rs) || (m_ex.rt == in.rt));
      e.hazard = haz;
      if (rst) begin
         m_ex  = '0;
         m_cnt = 0;
      end else if (fl || (!st && haz)) begin
         m_ex = '0;
         if (m_cnt < CNT_MAX) m_cnt++;
      end else if (!st) begin
         m_ex = in;
      end
      e.ex  = m_ex;
      e.cnt = 16'(m_cnt);
      q.push_back(e);
   endtask

   task automatic check_count(input string name, input logic [15:0] want);
      @(posedge clk);
      #2;
      n_checks++;
      if (count !== want) begin
         n_fail++;
         $display("FAIL %s: bubble_count_o=%h expected %h", name, count, want);
      end
   endtask

   function automatic slot_t rand_slot();
      slot_t s;
      s.valid       = ($urandom_range(0, 9) != 0);
      s.alu_control = 3'($urandom_range(0, 7));
      s.alu_src     = 1'($urandom);
      s.reg_dst     = 1'($urandom);
      s.reg_write   = 1'($urandom);
      s.mem_read    = 1'($urandom);
      s.mem_write   = 1'($urandom);
      s.mem_to_reg  = 1'($urandom);
      s.branch      = 1'($urandom);
      s.rd1         = $urandom;
      s.rd2         = $urandom;
      s.imm         = $urandom;
      s.pc4         = $urandom;
      s.rs          = 5'($urandom_range(0, 3));
      s.rt          = 5'($urandom_range(0, 3));
      s.rd          = 5'($urandom);
      return s;
   endfunction

   // Monitor: hazard is combinational, checked mid-cycle; state after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q[0];
            n_checks++;
            if (hazard !== e.hazard) begin
               n_fail++;
               $display("FAIL hazard @%0t: hazard_o=%b expected %b", $time, hazard, e.hazard);
            end
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_checks++;
            if (act !== e.ex) begin
               n_fail++;
               $display("FAIL ex_state @%0t: got %h expected %h", $time, act, e.ex);
            end
            n_checks++;
            if (count !== e.cnt) begin
               n_fail++;
               $display("FAIL count @%0t: got %h expected %h", $time, count, e.cnt);
            end
         end
      end
   end

   initial begin
      slot_t s;
      reset = 1'b1;
      flush = 1'b0;
      stall = 1'b0;
      id    = '0;
      m_ex  = '0;
      m_cnt = 0;

      drive(1'b1, 1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, 1'b0, '0);

      // Basic ADD load.
      s = '0;
      s.valid = 1'b1; s.alu_control = ALU_ADD; s.reg_dst = 1'b1; s.reg_write = 1'b1;
      s.rd1 = 32'd10; s.rd2 = 32'd20; s.rd = 5'd3; s.rs = 5'd1; s.rt = 5'd2;
      drive(1'b0, 1'b0, 1'b0, s);

      // Load-use: lw rt=8, then a consumer of r8 presented twice.
      s = '0;
      s.valid = 1'b1; s.alu_control = ALU_ADD; s.alu_src = 1'b1; s.reg_write = 1'b1;
      s.mem_read = 1'b1; s.mem_to_reg = 1'b1; s.rs = 5'd2; s.rt = 5'd8; s.imm = 32'd4;
      drive(1'b0, 1'b0, 1'b0, s);
      s = '0;
      s.valid = 1'b1; s.alu_control = ALU_OR; s.reg_dst = 1'b1; s.reg_write = 1'b1;
      s.rs = 5'd8; s.rt = 5'd4; s.rd = 5'd5; s.rd1 = 32'h1234;
      drive(1'b0, 1'b0, 1'b0, s);
      drive(1'b0, 1'b0, 1'b0, s);

      // Stall hold with SUB 50/20 latched while inputs change.
      s = '0;
      s.valid = 1'b1; s.alu_control = ALU_SUB; s.reg_dst = 1'b1; s.reg_write = 1'b1;
      s.rd1 = 32'd50; s.rd2 = 32'd20; s.rs = 5'd6; s.rt = 5'd7; s.rd = 5'd9;
      drive(1'b0, 1'b0, 1'b0, s);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, rand_slot());

      // Flush over stall.
      drive(1'b0, 1'b1, 1'b1, rand_slot());

      // No hazard on $zero or on an empty decode slot.
      s = '0;
      s.valid = 1'b1; s.mem_read = 1'b1; s.alu_control = ALU_ADD; s.rt = 5'd0;
      drive(1'b0, 1'b0, 1'b0, s);
      s.mem_read = 1'b0; s.rs = 5'd0; s.rt = 5'd3;
      drive(1'b0, 1'b0, 1'b0, s);
      s = '0;
      s.valid = 1'b1; s.mem_read = 1'b1; s.rt = 5'd9;
      drive(1'b0, 1'b0, 1'b0, s);
      s = '0;
      s.valid = 1'b0; s.rs = 5'd9; s.rt = 5'd9; s.rd1 = 32'hdead;
      drive(1'b0, 1'b0, 1'b0, s);

      // Pump flushes up to 0xFFFE, then three more to hit saturation.
      while (m_cnt < CNT_MAX - 1) drive(1'b0, 1'b1, 1'b0, rand_slot());
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, $urandom_range(0, 1) == 1, rand_slot());
      check_count("saturate", 16'hffff);

      // Reset lands even while stalled.
      drive(1'b0, 1'b0, 1'b0, rand_slot());
      drive(1'b0, 1'b0, 1'b1, rand_slot());
      drive(1'b1, 1'b0, 1'b1, rand_slot());
      check_count("reset_mid_stall", 16'h0000);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 4) == 0, rand_slot());
      end

      @(posedge clk);
      #3;
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Decode/Execute pipeline register that directly feeds the ALU and the execute-stage muxes.
- Latches decoded control and operand data each cycle.
- Detects load-use hazards against the instruction currently in Execute, and inserts bubbles on hazard or flush.
- Holds its contents on an external stall.
- Keeps a saturating bubble counter for performance debug.

Parameters:
DATA_W, 32, operand/immediate/PC width
REG_ADDR_W, 5, register specifier width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
stall_i  in  1  downstream/memory stall; hold all registers
flush_i  in  1  branch/jump taken; convert incoming instruction to bubble
id_valid_i  in  1  decode slot holds a real instruction
id_alu_control_i  in  3  ALU op (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
id_alu_src_i  in  1  B operand select: 1 = immediate
id_reg_dst_i  in  1  destination select: 1 = rd, 0 = rt
id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i, id_branch_i  in  1 each  control bits
id_rd1_i, id_rd2_i  in  DATA_W  register file read data
id_imm_i  in  DATA_W  sign-extended immediate
id_pc4_i  in  DATA_W  PC+4
id_rs_i, id_rt_i, id_rd_i  in  REG_ADDR_W  register specifiers
ex_*_o  out  (same widths)  registered copies of every id_*_i field above, including ex_valid_o
hazard_o  out  1  load-use detected; IF/ID and PC must hold this cycle
bubble_count_o  out  CNT_W  bubbles inserted since reset

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high.
- Reset: every ex_*_o output is 0, ex_valid_o is 0, and bubble_count_o is 0.
- hazard_o (combinational from registered state and current inputs):
  - hazard_o = ex_valid_o & ex_mem_read_o & id_valid_i & (ex_rt_o != 0) & (ex_rt_o == id_rs_i | ex_rt_o == id_rt_i).
  - The check is made against ex_rt_o only; no reg_dst decode, because loads always target rt.
- Per-edge priority, highest first:
  1. reset: clear everything.
  2. flush_i: load a bubble. flush_i wins over stall_i and hazard.
  3. stall_i: hold all ex_* registers. The counter is unchanged.
  4. hazard_o: load a bubble.
  5. Otherwise: load all id_* fields, with ex_valid_o <= id_valid_i.
- Bubble: every ex_* field is 0, including data, specifiers and alu_control. The result is ALU AND of 0,0, with no write, no memory access and no branch.
- Counter: bubble_count_o increments by 1 on each bubble load (flush or hazard) and saturates at all-ones with no wrap.
- Latency: exactly 1 cycle from id_* to ex_* when no stall, flush or hazard is present.
- Hazard resolution: a hazard lasts exactly one cycle. The bubble clears ex_mem_read_o, so the held decode instruction loads on the next edge.
- Simultaneous stall_i and hazard_o: hold. hazard_o stays asserted, so upstream keeps holding.
- Invalid decode slot: id_valid_i = 0 never raises hazard_o. It loads normally with ex_valid_o = 0 and is not counted as a bubble.
- Reset asserted mid-stall: clears on that edge regardless of stall_i.
- No combinational path from any id_* input to any ex_* output. hazard_o is the only combinational output.

Decomposition:
- Shared package mips_pkg:
  - ALU op constants ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_SLT = 3'b111.
  - Widths DATA_W and REG_ADDR_W.
  - Packed ex_ctrl_t holding valid, alu_control, alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch.
- Sub-module hazard_detect: the combinational load-use compare.
- The register and the counter remain in id_ex_reg.

Test Plan:
1. Basic load:
   - Stimulus: release reset; present ADD with rd1 = 10, rd2 = 20, rd = 3, valid = 1.
   - Response: next edge ex_alu_control_o = 010, ex_rd1_o = 10, ex_rd2_o = 20, ex_valid_o = 1. Counter stays 0.
2. Load-use:
   - Stimulus: load lw with rt = 8 and mem_read = 1. Next cycle present an instruction with rs = 8.
   - Response: hazard_o = 1. The following edge produces an all-zero bubble with count = 1, then the rs = 8 instruction loads and hazard_o = 0.
3. Stall hold:
   - Stimulus: with SUB rd1 = 50, rd2 = 20 latched, assert stall_i for 3 cycles while changing id_* inputs.
   - Response: ex_* outputs stay 50/20/110 throughout; count is unchanged.
4. Flush over stall:
   - Stimulus: assert flush_i and stall_i together.
   - Response: bubble loaded with ex_valid_o = 0 and count incremented.
5. Hazard ignored for $zero and invalid slots:
   - Stimulus: lw with rt = 0 followed by an instruction reading rs = 0. Separately, id_valid_i = 0 with a matching rs.
   - Response: hazard_o = 0 in both cases.
6. Saturation and reset:
   - Stimulus: force count to 0xFFFE, then apply 3 flushes.
   - Response: count reads 0xFFFF. Asserting reset mid-stall clears all outputs and the count on that edge.
